// File: rtl/hwag_core.sv
// HWAG register-file front end: a flop-based register bank behind an
// SSRAM-style parallel bus with a bidirectional data line.
module hwag_core #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int REG_COUNT  = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ssram_we,
   input  logic                  ssram_re,
   input  logic [ADDR_WIDTH-1:0] ssram_addr,
   inout  wire  [DATA_WIDTH-1:0] ssram_data,
   output logic [DATA_WIDTH-1:0] ssram_out [REG_COUNT]
);

   localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

   logic                  addr_ok;
   logic [IDX_W-1:0]      reg_idx;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  drive_en;

   // Full-width compare so out-of-range addresses never alias onto the bank.
   assign addr_ok = ({1'b0, ssram_addr} < (ADDR_WIDTH+1)'(REG_COUNT));
   assign reg_idx = ssram_addr[IDX_W-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            ssram_out[i] <= '0;
         end
      end else if (ssram_we && addr_ok) begin
         ssram_out[reg_idx] <= ssram_data;
      end
   end

   always_comb begin
      rd_data = '0;
      if (addr_ok) begin
         rd_data = ssram_out[reg_idx];
      end
   end

   // A host write always wins bus ownership; reset releases the bus at once.
   assign drive_en   = rst && ssram_re && !ssram_we;
   assign ssram_data = drive_en ? rd_data : 'z;

endmodule

// File: tb/tb_hwag_core.sv
// Directed bench for hwag_core: a scoreboard queue holds expected values
// pushed with each stimulus step and popped as bus / bank values are sampled.
module tb_hwag_core;

   localparam logic [15:0] BUS_FREE = 16'hFFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        ssram_we;
   logic        ssram_re;
   logic [7:0]  ssram_addr;
   logic        host_drive;
   logic [15:0] host_data;
   wire  [15:0] ssram_data;
   logic [15:0] ssram_out [64];

   logic [15:0] mdl [64];
   logic [15:0] exp_q [$];
   string       tag_q [$];
   int          checks = 0;
   int          errors = 0;

   // Released bus floats to all-ones through the pull-up.
   pullup pu_bus (ssram_data);
   assign ssram_data = host_drive ? host_data : 'z;

   hwag_core #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .REG_COUNT(64)) dut (
      .clk        (clk),
      .rst        (rst),
      .ssram_we   (ssram_we),
      .ssram_re   (ssram_re),
      .ssram_addr (ssram_addr),
      .ssram_data (ssram_data),
      .ssram_out  (ssram_out)
   );

   always #10 clk = ~clk;

   task automatic push_exp(input string tag, input logic [15:0] v);
      exp_q.push_back(v);
      tag_q.push_back(tag);
   endtask

   task automatic check_obs(input logic [15:0] obs);
      logic [15:0] e;
      string       t;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_underflow observed=%h expected=none", obs);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
         end
      end
   endtask

   task automatic compare_all(input string tag);
      for (int i = 0; i < 64; i++) begin
         push_exp($sformatf("%s_reg%0d", tag, i), mdl[i]);
         check_obs(ssram_out[i]);
      end
   endtask

   task automatic write_reg(input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      ssram_we   = 1'b1;
      ssram_re   = 1'b0;
      ssram_addr = a;
      host_data  = d;
      host_drive = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      ssram_we   = 1'b0;
      host_drive = 1'b0;
      if (a < 8'd64) mdl[a[5:0]] = d;
   endtask

   initial begin
      rst        = 1'b0;
      ssram_we   = 1'b0;
      ssram_re   = 1'b1;
      ssram_addr = 8'd0;
      host_drive = 1'b0;
      host_data  = 16'h0000;
      for (int i = 0; i < 64; i++) mdl[i] = 16'h0000;

      // Power-up: bus released during reset even with re high.
      #1;
      push_exp("rst_bus_released", BUS_FREE);
      check_obs(ssram_data);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 64; k++) begin
         ssram_addr = 8'(k);
         #1;
         push_exp($sformatf("powerup_read%0d", k), 16'h0000);
         check_obs(ssram_data);
      end
      ssram_re = 1'b0;

      // Sequential fill with data = 2*addr.
      for (int k = 0; k < 64; k++) write_reg(8'(k), 16'(2 * k));
      compare_all("fill");
      push_exp("fill_reg5", 16'h000A);  check_obs(ssram_out[5]);
      push_exp("fill_reg62", 16'h007C); check_obs(ssram_out[62]);
      push_exp("fill_reg63", 16'h007E); check_obs(ssram_out[63]);

      // Zero-latency read-back: address changes with no clock edge in between.
      @(negedge clk);
      ssram_re   = 1'b1;
      ssram_addr = 8'd62;
      #1;
      push_exp("readback62", 16'h007C); check_obs(ssram_data);
      ssram_addr = 8'd5;
      #1;
      push_exp("readback5", 16'h000A);  check_obs(ssram_data);

      // Bus ownership: we and re together write and never drive.
      @(negedge clk);
      ssram_we   = 1'b1;
      ssram_re   = 1'b1;
      ssram_addr = 8'd5;
      host_data  = 16'h1234;
      host_drive = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      push_exp("we_re_write5", 16'h1234); check_obs(ssram_out[5]);
      mdl[5]     = 16'h1234;
      ssram_we   = 1'b0;
      host_drive = 1'b0;
      #1;
      push_exp("we_re_readback5", 16'h1234); check_obs(ssram_data);
      ssram_we = 1'b1;
      #1;
      push_exp("we_forces_release_inrange", BUS_FREE); check_obs(ssram_data);
      ssram_addr = 8'd70;
      #1;
      push_exp("we_forces_release_oor", BUS_FREE); check_obs(ssram_data);
      ssram_we = 1'b0;
      ssram_re = 1'b0;

      // Out-of-range writes are ignored; out-of-range reads return zero.
      write_reg(8'd64, 16'hBEEF);
      write_reg(8'd200, 16'hBEEF);
      compare_all("oor_write");
      push_exp("oor_reg0", 16'h0000); check_obs(ssram_out[0]);
      @(negedge clk);
      ssram_re   = 1'b1;
      ssram_addr = 8'd64;
      #1;
      push_exp("oor_read64", 16'h0000); check_obs(ssram_data);
      ssram_addr = 8'd200;
      #1;
      push_exp("oor_read200", 16'h0000); check_obs(ssram_data);
      ssram_re = 1'b0;

      // Reset pulse straddling a clk edge while a write is held.
      @(negedge clk);
      ssram_we   = 1'b1;
      ssram_addr = 8'd9;
      host_data  = 16'h5A5A;
      host_drive = 1'b1;
      #5;
      rst = 1'b0;
      #1;
      for (int i = 0; i < 64; i++) mdl[i] = 16'h0000;
      compare_all("rst_async");
      @(posedge clk);
      #1;
      push_exp("rst_override_reg9", 16'h0000); check_obs(ssram_out[9]);
      ssram_we   = 1'b0;
      host_drive = 1'b0;
      ssram_re   = 1'b1;
      ssram_addr = 8'd5;
      #1;
      push_exp("rst_bus_released_re", BUS_FREE); check_obs(ssram_data);
      #3;
      rst      = 1'b1;
      ssram_re = 1'b0;
      write_reg(8'd3, 16'h0042);
      ssram_re   = 1'b1;
      ssram_addr = 8'd3;
      #1;
      push_exp("post_rst_read3", 16'h0042); check_obs(ssram_data);
      compare_all("post_rst");

      // Idle: strobes low, random addresses, bus never driven.
      ssram_re = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         ssram_addr = 8'($urandom_range(0, 255));
         #1;
         push_exp($sformatf("idle_bus%0d", c), BUS_FREE);
         check_obs(ssram_data);
      end
      compare_all("idle");

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hwag_core.md
Name: hwag_core

Overview:
- Register-file front end of the hardware angle generator (HWAG). It exposes a 64 x 16-bit register bank to an external SSRAM-style parallel bus with a bidirectional data line.
- Registers are written and read from a host running on an independent, slower clock.
- The bank contents are exported internally as array `ssram_out[0..63]`, which later HWAG datapath stages read.

Parameters:
- ADDR_WIDTH, 8, width of ssram_addr.
- DATA_WIDTH, 16, width of ssram_data and of each register.
- REG_COUNT, 64, number of implemented registers at addresses 0..REG_COUNT-1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low: rst=0 resets immediately, independent of clk.
- ssram_we  input  1  write strobe, active-high, level-sensitive.
- ssram_re  input  1  read strobe, active-high, level-sensitive.
- ssram_addr  input  ADDR_WIDTH  register address.
- ssram_data  inout  DATA_WIDTH  bidirectional data bus; tri-stated unless a read is active.

Behaviour:
- Storage: `ssram_out[0..REG_COUNT-1]`, DATA_WIDTH bits each, flip-flop based.
- Reset (rst=0, asynchronous):
  - all `ssram_out[i]` go to 16'h0000;
  - the ssram_data driver is released (high-Z) immediately and combinationally;
  - the bus stays released while rst=0, whatever the strobes are.
- Write:
  - Condition: rising edge of clk with rst=1, ssram_we=1 and ssram_addr < REG_COUNT.
  - Action: `ssram_out[ssram_addr] <= ssram_data`.
  - Level-sensitive: if we/addr/data are held for N clk edges, the same register is rewritten N times. This is harmless and intended.
  - Host contract: addr and data are held stable for at least 2 clk edges around the we window. No synchronizers on strobes/address; the host clock is slower and quasi-static relative to clk.
  - Latency: the written value is visible in `ssram_out` and on read-back from the next clk edge.
- Out-of-range write (addr >= REG_COUNT): ignored; no register changes; no aliasing by address truncation.
- Read:
  - Condition: rst=1, ssram_re=1, ssram_we=0.
  - ssram_data is driven combinationally with `ssram_out[ssram_addr]`, zero latency from addr change.
  - Out-of-range addr: drives 16'h0000.
- Bus release: otherwise ssram_data is high-Z.
  - ssram_we=1 always forces high-Z, so the block never fights the host while it writes.
  - Simultaneous we=1 and re=1: the write is performed, the bus is not driven.
- Reset mid-operation: an asserted rst overrides any write in the same cycle; the register stays 0.
  - After rst returns high, operation resumes on the next clk edge with no extra wait state.
- No wrap-around logic, counters or handshake acknowledgements; the host owns all sequencing.

Test Plan:
- Power-up: hold rst=0 for 2 clk, we=0, re=0 -> all 64 registers read 0x0000 afterwards; ssram_data high-Z during reset.
- Sequential fill:
  - stimulus: rst=1, we=1; host steps addr 0..63 every 3 clk with data = 2*addr; then we=0, re=1;
  - response: `ssram_out[k]` = 2k (e.g. [5]=0x000A, [62]=0x007C, [63]=0x007E);
  - read-back of addr 62 drives 0x007C on the bus with zero latency.
- Bus ownership: re=1 and we=1 together, addr=5, host drives 0x1234 -> register 5 becomes 0x1234; DUT never drives the bus; then we=0 -> bus reads 0x1234.
- Out of range:
  - write 0xBEEF to addr 64 and addr 200 -> no register changes (addr 0 still holds its prior value);
  - read addr 64 with re=1 -> 0x0000.
- Reset mid-write: during a fill, assert rst=0 for one half clk period coincident with a clk edge -> all registers 0x0000 and the bus is high-Z immediately; after release, the next write of 0x0042 to addr 3 reads back 0x0042.
- Idle: re=0, we=0, any addr -> ssram_data stays high-Z; register contents are unchanged over 100 clk.
